// File: rtl/ram_port_arbiter.sv
// Two-requester sequencer for the single-port 1024x32 RAM: fetch (read-only) and
// load/store share the macro; each access is held for ACCESS_CYCLES, then answered.
module ram_port_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [9:0]  if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [9:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [3:0] ACC_LAST   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] acc_cnt;
    logic [3:0] starve_cnt;
    logic       owner_d;
    logic       fetch_wins;

    // Load/store has priority unless fetch has lost STARVE_LIMIT times in a row.
    assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_MAX));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc_cnt    <= '0;
            starve_cnt <= '0;
            owner_d    <= 1'b0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state   <= ACCESS;
                        acc_cnt <= '0;
                        owner_d <= !fetch_wins;
                        if (fetch_wins) begin
                            if_gnt     <= 1'b1;
                            ram_addr   <= if_addr;
                            ram_we     <= 1'b0;
                            starve_cnt <= '0;
                        end else begin
                            d_gnt     <= 1'b1;
                            ram_addr  <= d_addr;
                            ram_we    <= d_we;
                            ram_wdata <= d_wdata;
                            if (if_req && (starve_cnt != STARVE_MAX))
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    if (acc_cnt == ACC_LAST) begin
                        state  <= RESP;
                        ram_we <= 1'b0;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            // A store leaves the previous load data in place.
                            if (!ram_we)
                                d_rdata <= ram_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= ram_rdata;
                        end
                    end else begin
                        acc_cnt <= acc_cnt + 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
